// File: rtl/lfsr_checker.sv
// lfsr_checker: lock onto an x^4+x^3+1 Fibonacci LFSR bit stream and count bit errors while locked
module lfsr_checker #(
  parameter int LOCK_MATCHES = 8,
  parameter int LOSS_ERRS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       clear_cnt,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int LW = $clog2(LOSS_ERRS + 1);
  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
  state_t        state, state_nx;
  logic [3:0]    hist, hist_nx, rx4;
  logic [2:0]    rx;
  logic [1:0]    fill_cnt, fill_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic [LW-1:0] loss_cnt, loss_nx;
  logic [7:0]    count_nx;
  logic          pred, hit, pulse_nx;
  assign pred = hist[3] ^ hist[2];
  assign hit  = (bit_in == pred) && (hist != 4'b0000);
  assign rx4  = {rx, bit_in};
  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill_cnt;
    match_nx = match_cnt;
    loss_nx  = loss_cnt;
    pulse_nx = 1'b0;
    count_nx = err_count;
    if (bit_valid) begin
      unique case (state)
        FILL: begin
          hist_nx  = {hist[2:0], bit_in};
          fill_nx  = fill_cnt + 2'd1;
          state_nx = fill_cnt == 2'd3 ? SEARCH : FILL;
        end
        SEARCH: begin
          hist_nx  = {hist[2:0], bit_in};
          match_nx = hit ? match_cnt + 1'b1 : '0;
          if (hit && match_cnt == MW'(LOCK_MATCHES - 1)) begin
            state_nx = LOCKED;
            match_nx = '0;
            loss_nx  = '0;
          end
        end
        LOCKED: begin
          // flywheel: keep predicting from our own sequence, not the received bits
          hist_nx  = {hist[2:0], pred};
          pulse_nx = bit_in != pred;
          loss_nx  = pulse_nx ? loss_cnt + 1'b1 : '0;
          count_nx = pulse_nx && err_count != 8'hff ? err_count + 8'd1 : err_count;
          if (pulse_nx && loss_cnt == LW'(LOSS_ERRS - 1)) begin
            state_nx = SEARCH;
            hist_nx  = rx4;
            match_nx = '0;
            loss_nx  = '0;
          end
        end
        default: state_nx = FILL;
      endcase
    end
    if (clear_cnt) count_nx = 8'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      hist      <= 4'b0000;
      rx        <= 3'b000;
      fill_cnt  <= 2'd0;
      match_cnt <= '0;
      loss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nx;
      hist      <= hist_nx;
      rx        <= bit_valid ? rx4[2:0] : rx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      loss_cnt  <= loss_nx;
      locked    <= state_nx == LOCKED;
      err_pulse <= pulse_nx;
      err_count <= count_nx;
    end
  end
endmodule
